serial_subtractor: RTL and testbench

- Bit-serial N-bit unsigned subtractor computing a - b - bin, processing one bit per clock, LSB first.
- Built around a one-bit full-subtractor cell and a single borrow flip-flop.
- Companion to the combinational full-adder family: it performs the inverse operation, sequenced over time.
- Serves as the area-minimal arithmetic option for slow datapaths; exposes a start/busy/done handshake to its controller.

---
 rtl/serial_subtractor_pkg.sv | 12 +
 rtl/full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 112 +++++++++++
 tb/tb_serial_subtractor.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: computes x - y - bin, giving difference d and borrow bout.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, a - b - bin, one bit per clock LSB first.
// Result is valid on the done pulse, WIDTH+1 cycles after start; start is ignored while busy.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset_p,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic bit_d;
  logic bit_bout;

  full_subtractor u_fs (
    .x    (a_sr_q[0]),
    .y    (b_sr_q[0]),
    .bin  (br_q),
    .d    (bit_d),
    .bout (bit_bout)
  );

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    res_d   = res_q;
    diff_d  = diff_q;
    br_d    = br_q;
    bout_d  = bout_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b;
          br_d    = bin;
          res_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        res_d  = {bit_d, res_q[WIDTH-1:1]};
        br_d   = bit_bout;
        cnt_d  = cnt_q + 1'b1;
        // Publish on the final bit so diff/bout are already valid during DONE.
        if (cnt_q == CW'(WIDTH - 1)) begin
          diff_d  = {bit_d, res_q[WIDTH-1:1]};
          bout_d  = bit_bout;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor and its full_subtractor cell.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_p;
  logic         start;
  logic [W-1:0] a, b;
  logic         bin;
  logic         busy, done;
  logic [W-1:0] diff;
  logic         bout;

  logic fs_x, fs_y, fs_bin, fs_d, fs_bout;

  int n_checks = 0;
  int n_fail   = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_p (reset_p),
    .start   (start),
    .a       (a),
    .b       (b),
    .bin     (bin),
    .busy    (busy),
    .done    (done),
    .diff    (diff),
    .bout    (bout)
  );

  full_subtractor u_fs_dut (
    .x    (fs_x),
    .y    (fs_y),
    .bin  (fs_bin),
    .d    (fs_d),
    .bout (fs_bout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: borrow is the sign of the widened unsigned difference.
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    int r;
    r = int'(x) - int'(y) - int'(c);
    model[W-1:0] = W'(r & ((1 << W) - 1));
    model[W]     = (r < 0);
  endfunction

  task automatic run_op(input logic [W-1:0] a_i, input logic [W-1:0] b_i, input logic bin_i,
                        output logic [W-1:0] d_o, output logic bo_o,
                        output int lat, output int busy_n);
    a = a_i; b = b_i; bin = bin_i; start = 1'b1;
    tick;
    start = 1'b0;
    lat = 1;
    busy_n = busy ? 1 : 0;
    while (!done && lat < 50) begin
      tick;
      lat++;
      if (busy) busy_n++;
    end
    if (lat >= 50) check("done_timeout", 32'(lat), 32'(W + 1));
    d_o  = diff;
    bo_o = bout;
    tick;
  endtask

  initial begin
    logic [W-1:0] gd;
    logic         gb;
    logic [W:0]   ref_v;
    int           lat, bn, dones;
    logic [W-1:0] ra, rb;
    logic         rc;
    logic [2:0]   v;

    reset_p = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    fs_x = 1'b0; fs_y = 1'b0; fs_bin = 1'b0;
    tick; tick;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_diff", 32'(diff), 0);
    check("rst_bout", 32'(bout), 0);
    reset_p = 1'b0;
    tick;

    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      fs_x = v[2]; fs_y = v[1]; fs_bin = v[0];
      #1;
      check("fs_d", 32'(fs_d), 32'((int'(v[2]) - int'(v[1]) - int'(v[0])) & 1));
      check("fs_bout", 32'(fs_bout), 32'(int'(v[2]) < int'(v[1]) + int'(v[0])));
    end

    run_op(8'd100, 8'd37, 1'b0, gd, gb, lat, bn);
    check("t1_diff", 32'(gd), 63);
    check("t1_bout", 32'(gb), 0);
    check("t1_latency", 32'(lat), 9);
    check("t1_busy_cycles", 32'(bn), 9);
    check("t1_done_pulse", 32'(done), 0);
    check("t1_busy_after", 32'(busy), 0);
    check("t1_hold_diff", 32'(diff), 63);

    run_op(8'd5, 8'd9, 1'b0, gd, gb, lat, bn);
    check("t2_diff", 32'(gd), 252);
    check("t2_bout", 32'(gb), 1);
    run_op(8'd0, 8'd0, 1'b1, gd, gb, lat, bn);
    check("t3_diff", 32'(gd), 255);
    check("t3_bout", 32'(gb), 1);
    run_op(8'd255, 8'd255, 1'b0, gd, gb, lat, bn);
    check("t4_diff", 32'(gd), 0);
    check("t4_bout", 32'(gb), 0);
    run_op(8'd255, 8'd0, 1'b1, gd, gb, lat, bn);
    check("t5_diff", 32'(gd), 254);
    check("t5_bout", 32'(gb), 0);
    check("t5_latency", 32'(lat), 9);

    // Restarts mid-operation with scrambled operands must be ignored.
    a = 8'd200; b = 8'd50; bin = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    dones = 0; gd = '0; gb = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      start = (k == 3 || k == 8);
      if (start) begin
        a = W'($urandom); b = W'($urandom); bin = 1'b1;
      end
      tick;
      if (done) begin
        dones++; gd = diff; gb = bout;
      end
    end
    start = 1'b0;
    check("ign_dones", 32'(dones), 1);
    check("ign_diff", 32'(gd), 150);
    check("ign_bout", 32'(gb), 0);

    // Reset in the middle of an operation.
    a = 8'd123; b = 8'd45; bin = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    tick; tick; tick;
    reset_p = 1'b1;
    tick;
    reset_p = 1'b0;
    check("mrst_busy", 32'(busy), 0);
    check("mrst_done", 32'(done), 0);
    check("mrst_diff", 32'(diff), 0);
    check("mrst_bout", 32'(bout), 0);
    dones = 0;
    for (int k = 0; k < 15; k++) begin
      tick;
      if (done) dones++;
    end
    check("mrst_no_done", 32'(dones), 0);
    run_op(8'd77, 8'd200, 1'b1, gd, gb, lat, bn);
    check("mrst_new_diff", 32'(gd), 132);
    check("mrst_new_bout", 32'(gb), 1);

    // Reset and start together: the start is lost.
    a = 8'd9; b = 8'd3; start = 1'b1; reset_p = 1'b1;
    tick;
    start = 1'b0; reset_p = 1'b0;
    check("rst_start_busy", 32'(busy), 0);

    for (int n = 0; n < 1000; n++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      ref_v = model(ra, rb, rc);
      run_op(ra, rb, rc, gd, gb, lat, bn);
      check("rnd_diff", 32'(gd), 32'(ref_v[W-1:0]));
      check("rnd_bout", 32'(gb), 32'(ref_v[W]));
      if (n % 100 == 0) check("rnd_latency", 32'(lat), 32'(W + 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
